// File: rtl/stream_dispatcher.sv
// stream_dispatcher: 1:N valid/ready fan-out with a 2-entry FIFO per port.
//   clk, rst (sync active-low)
//   valid_in/data_in/dest_in -> ready_out : upstream word tagged with port index
//   valid_out/data_out <- ready_in        : per-port downstream streams, port i
//                                           in data_out[(i+1)*DW-1 -: DW]
//   drop_cnt : saturating count of words sunk for an out-of-range dest_in
// Upstream ready depends only on registered fill state and dest_in, never on
// ready_in, so the FIFOs break the combinational ready path.

// Per-port 2-entry FIFO.
module stream_dispatcher_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic          full
);
  logic [1:0][DW-1:0] mem;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         cnt;
  logic               wr, pop;

  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);
  assign dout  = mem[rd_ptr];
  assign pop   = valid & ready;
  // A full port never takes a word, even when it pops in the same cycle.
  assign wr    = push & ~full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module stream_dispatcher #(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8,
  parameter int DEST_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DW-1:0]           data_in,
  input  logic [DEST_W-1:0]       dest_in,
  output logic                    ready_out,
  output logic [REQ_WIDTH-1:0]    valid_out,
  output logic [REQ_WIDTH*DW-1:0] data_out,
  input  logic [REQ_WIDTH-1:0]    ready_in,
  output logic [7:0]              drop_cnt
);
  logic [REQ_WIDTH-1:0] full, push;
  logic                 legal, sel_full;

  always_comb begin
    legal    = (int'(dest_in) < REQ_WIDTH);
    sel_full = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++)
      if (dest_in == DEST_W'(i)) sel_full = full[i];
    // Illegal words are always consumed so they cannot wedge the stream.
    ready_out = legal ? ~sel_full : 1'b1;
  end

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_port
    assign push[i] = valid_in & ready_out & legal & (dest_in == DEST_W'(i));
    stream_dispatcher_port #(.DW(DW)) u_port (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (data_in),
      .ready (ready_in[i]),
      .valid (valid_out[i]),
      .dout  (data_out[i*DW +: DW]),
      .full  (full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst)
      drop_cnt <= 8'd0;
    else if (valid_in && !legal && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
endmodule

// File: tb/tb_stream_dispatcher.sv
module tb_stream_dispatcher;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = '0;
  logic [1:0]  dest_in = '0;
  logic        ready_out;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic [3:0]  ready_in = '0;
  logic [7:0]  drop_cnt;

  // Second instance with 3 ports so dest 3 is illegal.
  logic        valid3 = 1'b0;
  logic [7:0]  data3 = '0;
  logic [1:0]  dest3 = 2'd3;
  logic        ready_out3;
  logic [2:0]  valid_out3;
  logic [23:0] data_out3;
  logic [2:0]  ready_in3 = 3'b111;
  logic [7:0]  drop_cnt3;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per port, plus drop counters.
  logic [7:0] q[4][$];
  int  drop_m3 = 0;
  bit  started = 0, just_reset = 0, last_acc = 0;

  stream_dispatcher #(.REQ_WIDTH(4), .DW(8), .DEST_W(2)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .dest_in(dest_in), .ready_out(ready_out), .valid_out(valid_out),
    .data_out(data_out), .ready_in(ready_in), .drop_cnt(drop_cnt));

  stream_dispatcher #(.REQ_WIDTH(3), .DW(8), .DEST_W(2)) dut3 (
    .clk(clk), .rst(rst), .valid_in(valid3), .data_in(data3),
    .dest_in(dest3), .ready_out(ready_out3), .valid_out(valid_out3),
    .data_out(data_out3), .ready_in(ready_in3), .drop_cnt(drop_cnt3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the
  // model on the rising edge. Inputs are changed by the caller after return.
  task automatic step();
    bit exp_rdy, acc;
    @(negedge clk);
    exp_rdy = (q[dest_in].size() != 2);
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid_out[%0d]", i), 32'(valid_out[i]), 32'(q[i].size() != 0));
        if (q[i].size() != 0)
          chk($sformatf("data_out[%0d]", i), 32'(data_out[i*8 +: 8]), 32'(q[i][0]));
      end
      chk("ready_out", 32'(ready_out), 32'(exp_rdy));
      chk("drop_cnt", 32'(drop_cnt), 32'd0);
      chk("ready_out3", 32'(ready_out3), 32'd1);
      chk("valid_out3", 32'(valid_out3), 32'd0);
      chk("drop_cnt3", 32'(drop_cnt3), 32'(drop_m3));
      if (just_reset) chk("data_out_after_reset", data_out, 32'd0);
    end
    acc = valid_in & exp_rdy & rst;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      drop_m3    = 0;
      started    = 1;
      just_reset = 1;
    end else begin
      just_reset = 0;
      for (int i = 0; i < 4; i++)
        if (ready_in[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (acc) q[dest_in].push_back(data_in);
      if (valid3 && drop_m3 < 255) drop_m3++;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [7:0] v);
    valid_in = 1'b1; dest_in = d; data_in = v;
    step();
  endtask

  initial begin
    // 1: reset then a single word to port 2 with no downstream ready
    rst = 1'b0; step(); step();
    rst = 1'b1; ready_in = 4'b0000;
    send(2'd2, 8'hA5);
    chk("t1_accept", 32'(last_acc), 32'd1);
    valid_in = 1'b0; step();
    chk("t1_valid_out", 32'(valid_out), 32'h4);
    chk("t1_data", 32'(data_out[23:16]), 32'hA5);
    ready_in = 4'b0100; step(); ready_in = 4'b0000;

    // 2: fill port 1, third word stalls, then drain in order
    send(2'd1, 8'h01); send(2'd1, 8'h02);
    send(2'd1, 8'h03);
    chk("t2_stall", 32'(last_acc), 32'd0);
    step();
    ready_in = 4'b0010;
    for (int k = 0; k < 10 && !last_acc; k++) step();
    chk("t2_accept", 32'(last_acc), 32'd1);
    valid_in = 1'b0;
    repeat (4) step();

    // 3: streaming 16 words to port 0 with ready held
    ready_in = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      send(2'd0, 8'($urandom));
      chk("t3_rate", 32'(last_acc), 32'd1);
    end
    valid_in = 1'b0; repeat (2) step();

    // 4: port 3 full and stalled; port 0 still accepts; dest 3 blocks
    ready_in = 4'b0000;
    send(2'd3, 8'h31); send(2'd3, 8'h32);
    send(2'd0, 8'h0A);
    chk("t4_port0_accept", 32'(last_acc), 32'd1);
    send(2'd3, 8'h33);
    step(); step();
    chk("t4_hol_stall", 32'(last_acc), 32'd0);
    ready_in = 4'b1000;
    for (int k = 0; k < 10 && !last_acc; k++) step();
    chk("t4_accept", 32'(last_acc), 32'd1);
    valid_in = 1'b0; ready_in = 4'b1111; repeat (4) step();

    // 5: 300 illegal words on the 3-port instance; drop count saturates
    valid3 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      data3 = 8'($urandom);
      step();
    end
    valid3 = 1'b0; step();
    chk("t5_drop_sat", 32'(drop_cnt3), 32'd255);

    // 6: reset with ports 0 and 2 holding 2 words each
    ready_in = 4'b0000;
    send(2'd0, 8'h10); send(2'd0, 8'h11); send(2'd2, 8'h20); send(2'd2, 8'h21);
    valid_in = 1'b1; dest_in = 2'd1; data_in = 8'hEE;
    rst = 1'b0; step();
    chk("t6_no_accept_in_reset", 32'(last_acc), 32'd0);
    rst = 1'b1; valid_in = 1'b0; step();
    chk("t6_valid_cleared", 32'(valid_out), 32'd0);
    chk("t6_drop3_cleared", 32'(drop_cnt3), 32'd0);
    send(2'd0, 8'h5C);
    valid_in = 1'b0; step();
    chk("t6_alone", 32'(valid_out), 32'h1);
    chk("t6_data", 32'(data_out[7:0]), 32'h5C);
    ready_in = 4'b1111; step();

    // Random traffic, holding inputs stable while stalled
    for (int k = 0; k < 600; k++) begin
      if (!(valid_in && !last_acc)) begin
        valid_in = 1'($urandom);
        dest_in  = 2'($urandom);
        data_in  = 8'($urandom);
      end
      ready_in = 4'($urandom);
      valid3   = 1'($urandom);
      data3    = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_dispatcher.md
Name: stream_dispatcher

Overview:
- 1:N dispatcher for the valid/ready streaming interface; the fan-out counterpart to the N:1 round-robin arbiter.
- Accepts one upstream stream tagged with a destination index and routes each word to one of REQ_WIDTH downstream ports.
- Each downstream port has a 2-entry FIFO, so upstream ready never depends combinationally on any downstream ready.
- Illegal destinations are sunk and counted.

Parameters:
- REQ_WIDTH, 4, number of downstream ports (1..2**DEST_W).
- DW, 8, data width per word.
- DEST_W, 2, width of the destination index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low; sampled on the rising edge of clk.
- valid_in  input  1  upstream word valid.
- data_in  input  DW  upstream word.
- dest_in  input  DEST_W  destination port index; qualified by valid_in.
- ready_out  output  1  upstream ready.
- valid_out  output  REQ_WIDTH  per-port downstream valid.
- data_out  output  REQ_WIDTH*DW  per-port word; port i occupies bits [(i+1)*DW-1 -: DW].
- ready_in  input  REQ_WIDTH  per-port downstream ready.
- drop_cnt  output  8  saturating count of words dropped for illegal destination.

Behaviour:
- Per-port state:
  - 2-entry storage, 1-bit write pointer, 1-bit read pointer, 2-bit count cnt[i] in 0..2.
- Illegal destination: legal = (dest_in < REQ_WIDTH).
- ready_out:
  - If legal: ready_out = (cnt[dest_in] != 2).
  - If not legal: ready_out = 1.
  - Combinational from registered count and dest_in only; never a function of ready_in.
- Push: push[i] = valid_in & ready_out & legal & (dest_in == i).
  - Writes data_in at wr_ptr[i], then toggles wr_ptr[i].
- valid_out[i] = (cnt[i] != 0). data_out slice i = storage[i][rd_ptr[i]].
- Pop: pop[i] = valid_out[i] & ready_in[i].
  - Toggles rd_ptr[i].
- Count update:
  - cnt[i] += push[i] - pop[i].
  - Push and pop in the same cycle leave cnt unchanged.
  - Full port (cnt=2) never pushes, even if popping that cycle.
- Drop: valid_in & ~legal.
  - Word consumed (handshake completes) and discarded.
  - drop_cnt increments by 1, saturating at 255.
- Latency:
  - A word accepted in cycle T is visible on valid_out/data_out of its port in cycle T+1 at the earliest.
  - Throughput is 1 word/cycle to any single port whose downstream is always ready.
- Ordering:
  - Strict FIFO order per port.
  - No ordering guarantee across ports.
  - A stalled port blocks upstream only while the head word targets that port (head-of-line blocking by design).
- data_in/dest_in may change freely while valid_in=0. While valid_in=1 and ready_out=0, the upstream source must hold them stable.
- Reset (rst=0 on a clock edge):
  - All cnt, pointers, storage and drop_cnt cleared to 0.
  - valid_out = 0, data_out = 0, drop_cnt = 0.
  - ready_out is 1 the cycle after reset deasserts.
- Reset mid-operation: all buffered words are discarded with no downstream handshake; upstream words presented during reset are not accepted.
- Boundary cases:
  - cnt=1 with simultaneous push+pop: the old head leaves and the new word becomes the head next cycle.
  - cnt=0 with push: no same-cycle bypass; the word appears next cycle.
  - REQ_WIDTH = 2**DEST_W: no illegal destination exists; drop_cnt stays 0.

Test Plan:
1. Reset then single word: rst=0 for 2 cycles, then valid_in=1, dest_in=2, data_in=8'hA5 for one cycle with ready_in=4'b0000 -> accepted. Next cycle valid_out=4'b0100 and data_out[23:16]=8'hA5; other valid_out bits stay 0.
2. Fill and backpressure: three consecutive words 8'h01, 8'h02, 8'h03 to dest 1, with ready_in[1]=0 -> first two accepted and ready_out=0 on the third. Raise ready_in[1] -> port 1 emits 01, 02, then 03 in order, and ready_out returns to 1 one cycle after the first pop.
3. Streaming push/pop: 16 words to dest 0 with ready_in[0]=1 held -> 1 word/cycle, cnt[0] never exceeds 1, output sequence identical to input, valid_out[0] lags valid_in by 1 cycle.
4. Head-of-line and independence: port 3 full with ready_in[3]=0; push to dest 0 succeeds, while a word to dest 3 stalls ready_out=0 until ready_in[3]=1 frees an entry. Port 0 output is unaffected throughout.
5. Illegal destination: REQ_WIDTH=3, DEST_W=2, 300 words with dest_in=3 -> ready_out=1 every cycle, no valid_out asserted, drop_cnt saturates at 255.
6. Reset mid-operation: ports 0 and 2 each hold 2 words; assert rst=0 for 1 cycle -> next cycle valid_out=0 and drop_cnt=0. A new word to dest 0 then appears alone, with no stale data.
